// File: rtl/obstacle_sched.sv
// obstacle_sched: schedules Dino-track obstacles. Spawns them into free slots
// after a gap, advances them one movement step every STEP_DIV clocks at a
// level-dependent speed, and retires them at TRACK_END.
//
// Optional feature macro: OBS_LFSR_EN
//   defined     -> gap reload = MIN_GAP + LFSR[5:0] (8-bit LFSR, taps 8,6,5,4)
//   not defined -> no LFSR, gap reload = MIN_GAP + 32
//
// Ports:
//   clk       master clock
//   clr       synchronous active-high reset, overrides run/halt
//   run       game running; low clears the track
//   halt      game over; freezes the track while run is high
//   level     speed level, an advancing slot moves 1+level per step
//   obs_pos   packed slot positions, slot i at [9i+8:9i]
//   obs_valid slot active flags
//   hit_zone  some valid slot lies in HIT_LO..HIT_HI (from registered state)
//   passed    one-cycle pulse on a step that retired at least one obstacle
//   step      one-cycle pulse on each movement step
module obstacle_sched #(
    parameter int unsigned NUM_OBS   = 3,
    parameter int unsigned STEP_DIV  = 50000,
    parameter int unsigned TRACK_END = 480,
    parameter int unsigned HIT_LO    = 401,
    parameter int unsigned HIT_HI    = 469,
    parameter int unsigned MIN_GAP   = 40,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   run,
    input  logic                   halt,
    input  logic [1:0]             level,
    output logic [9*NUM_OBS-1:0]   obs_pos,
    output logic [NUM_OBS-1:0]     obs_valid,
    output logic                   hit_zone,
    output logic                   passed,
    output logic                   step
);

    localparam int unsigned PW  = 9;
    localparam int unsigned GW  = 9;
    localparam int unsigned PSW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned IW  = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;

    logic [NUM_OBS-1:0][PW-1:0] pos_q, pos_n;
    logic [NUM_OBS-1:0]         valid_q, valid_n;
    logic [PSW-1:0]             presc_q, presc_n;
    logic [GW-1:0]              gap_q, gap_n;
    logic                       step_q, step_n;
    logic                       passed_q, passed_n;

    logic [PW-1:0]              adv;
    logic [GW-1:0]              gap_dec;
    logic [GW-1:0]              reload;
    logic                       free_found;
    logic [IW-1:0]              free_idx;
    logic                       hit;

`ifdef OBS_LFSR_EN
    logic [7:0] lfsr_q, lfsr_n;
    assign reload = GW'(MIN_GAP) + GW'(lfsr_q[5:0]);
`else
    assign reload = GW'(MIN_GAP + 32);
`endif

    // Lowest-index slot that was free before this step.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_OBS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    // Next-state: mode selection, prescaler, advance/retire/gap/spawn.
    always_comb begin
        pos_n    = pos_q;
        valid_n  = valid_q;
        presc_n  = presc_q;
        gap_n    = gap_q;
        step_n   = 1'b0;
        passed_n = 1'b0;
        adv      = '0;
        gap_dec  = '0;
`ifdef OBS_LFSR_EN
        lfsr_n   = lfsr_q;
`endif
        if (!run) begin
            pos_n   = '0;
            valid_n = '0;
            presc_n = '0;
            gap_n   = GW'(MIN_GAP);
        end else if (!halt) begin
            if (presc_q == PSW'(STEP_DIV - 1)) begin
                presc_n = '0;
                step_n  = 1'b1;
                for (int i = 0; i < NUM_OBS; i++) begin
                    if (valid_q[i]) begin
                        adv = pos_q[i] + PW'(1) + PW'(level);
                        if (adv >= PW'(TRACK_END)) begin
                            valid_n[i] = 1'b0;
                            pos_n[i]   = '0;
                            passed_n   = 1'b1;
                        end else begin
                            pos_n[i] = adv;
                        end
                    end
                end
                // Spawn fires on the step the gap count reaches zero, so
                // consecutive spawns are exactly 'reload' steps apart.
                gap_dec = (gap_q != '0) ? gap_q - GW'(1) : '0;
                gap_n   = gap_dec;
                if (gap_dec == '0 && free_found) begin
                    valid_n[free_idx] = 1'b1;
                    pos_n[free_idx]   = '0;
                    gap_n             = reload;
`ifdef OBS_LFSR_EN
                    lfsr_n = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
                end
            end else begin
                presc_n = presc_q + PSW'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            pos_q    <= '0;
            valid_q  <= '0;
            presc_q  <= '0;
            gap_q    <= GW'(MIN_GAP);
            step_q   <= 1'b0;
            passed_q <= 1'b0;
        end else begin
            pos_q    <= pos_n;
            valid_q  <= valid_n;
            presc_q  <= presc_n;
            gap_q    <= gap_n;
            step_q   <= step_n;
            passed_q <= passed_n;
        end
    end

`ifdef OBS_LFSR_EN
    // LFSR holds outside spawns, including while idle.
    always_ff @(posedge clk) begin
        if (clr) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_n;
    end
`endif

    // Collision zone flag from registered slots.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (valid_q[i] && pos_q[i] >= PW'(HIT_LO) && pos_q[i] <= PW'(HIT_HI))
                hit = 1'b1;
        end
    end

    assign obs_pos   = pos_q;
    assign obs_valid = valid_q;
    assign hit_zone  = hit;
    assign passed    = passed_q;
    assign step      = step_q;

endmodule

// File: tb/tb_obstacle_sched.sv
// Bench for obstacle_sched: directed phases with randomized level/halt
// activity, checked each cycle against an event-level reference model.
module tb_obstacle_sched;

    localparam int unsigned NUM_OBS   = 3;
    localparam int unsigned STEP_DIV  = 4;
    localparam int unsigned TRACK_END = 480;
    localparam int unsigned HIT_LO    = 401;
    localparam int unsigned HIT_HI    = 469;
    localparam int unsigned MIN_GAP   = 2;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;

    logic                  clk = 1'b0;
    logic                  clr, run, halt;
    logic [1:0]            level;
    logic [9*NUM_OBS-1:0]  obs_pos;
    logic [NUM_OBS-1:0]    obs_valid;
    logic                  hit_zone, passed, step;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         m_pos [NUM_OBS];
    bit         m_valid [NUM_OBS];
    int         m_presc, m_gap;
    logic [7:0] m_lfsr;
    bit         m_step, m_passed;

    obstacle_sched #(
        .NUM_OBS(NUM_OBS), .STEP_DIV(STEP_DIV), .TRACK_END(TRACK_END),
        .HIT_LO(HIT_LO), .HIT_HI(HIT_HI), .MIN_GAP(MIN_GAP), .LFSR_SEED(LFSR_SEED)
    ) dut (
        .clk(clk), .clr(clr), .run(run), .halt(halt), .level(level),
        .obs_pos(obs_pos), .obs_valid(obs_valid), .hit_zone(hit_zone),
        .passed(passed), .step(step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One movement step of the game rules.
    task automatic model_step();
        int free = -1;
        int np;
        for (int i = 0; i < NUM_OBS; i++)
            if (!m_valid[i] && free < 0) free = i;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (m_valid[i]) begin
                np = m_pos[i] + 1 + int'(level);
                if (np >= int'(TRACK_END)) begin
                    m_valid[i] = 0;
                    m_pos[i]   = 0;
                    m_passed   = 1;
                end else begin
                    m_pos[i] = np;
                end
            end
        end
        if (m_gap > 0) m_gap = m_gap - 1;
        if (m_gap == 0 && free >= 0) begin
            m_valid[free] = 1;
            m_pos[free]   = 0;
`ifdef OBS_LFSR_EN
            m_gap  = int'(MIN_GAP) + int'(m_lfsr[5:0]);
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`else
            m_gap = int'(MIN_GAP) + 32;
`endif
        end
    endtask

    // Model update for one clock edge using the inputs present at that edge.
    task automatic model_clock();
        m_step   = 0;
        m_passed = 0;
        if (clr) begin
            for (int i = 0; i < NUM_OBS; i++) begin m_pos[i] = 0; m_valid[i] = 0; end
            m_presc = 0;
            m_gap   = int'(MIN_GAP);
            m_lfsr  = LFSR_SEED;
        end else if (!run) begin
            for (int i = 0; i < NUM_OBS; i++) begin m_pos[i] = 0; m_valid[i] = 0; end
            m_presc = 0;
            m_gap   = int'(MIN_GAP);
        end else if (!halt) begin
            if (m_presc == int'(STEP_DIV) - 1) begin
                m_presc = 0;
                m_step  = 1;
                model_step();
            end else begin
                m_presc = m_presc + 1;
            end
        end
    endtask

    task automatic compare();
        logic [31:0] ep, ev;
        bit eh;
        ep = '0; ev = '0; eh = 0;
        for (int i = 0; i < NUM_OBS; i++) begin
            ep[9*i +: 9] = 9'(m_pos[i]);
            ev[i]        = m_valid[i];
            if (m_valid[i] && m_pos[i] >= int'(HIT_LO) && m_pos[i] <= int'(HIT_HI)) eh = 1;
        end
        chk("obs_pos",   32'(obs_pos),   ep);
        chk("obs_valid", 32'(obs_valid), ev);
        chk("hit_zone",  32'(hit_zone),  32'(eh));
        chk("step",      32'(step),      32'(m_step));
        chk("passed",    32'(passed),    32'(m_passed));
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        compare();
    endtask

    initial begin
        clr = 1'b1; run = 1'b0; halt = 1'b0; level = 2'd0;
        for (int i = 0; i < NUM_OBS; i++) begin m_pos[i] = 0; m_valid[i] = 0; end
        m_presc = 0; m_gap = 0; m_lfsr = LFSR_SEED; m_step = 0; m_passed = 0;
        #1;
        // Reset.
        repeat (3) tick();

        // Level 0 run: fills every slot, walks through the hit-zone edges, retires.
        clr = 1'b0; run = 1'b1;
        repeat (2500) tick();

        // Random level changes and freeze periods.
        for (int c = 0; c < 4000; c++) begin
            tick();
            if ($urandom_range(0, 49) == 0) level = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) halt = ~halt;
        end

        // Long freeze.
        halt = 1'b1;
        repeat (40) tick();
        halt = 1'b0;
        repeat (200) tick();

        // Drop run, then restart.
        run = 1'b0;
        repeat (5) tick();
        run = 1'b1;
        level = 2'($urandom_range(0, 3));
        repeat (600) tick();

        // Reset during run, overriding run and halt.
        clr = 1'b1; halt = 1'b1;
        tick();
        clr = 1'b0; halt = 1'b0;
        repeat (300) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
